// File: rtl/fft_pkg.sv
// Shared constants, state type and index helpers for the FFT datapath blocks
// (frame streamer today, IFFT and spectrum stages later).
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_W     = 16;
    localparam int FFT_LOG2N = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } fft_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] rev;
        rev = '0;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            rev[i] = idx[FFT_LOG2N-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_lane_select.sv
// Combinational N:1 selector of one W-bit lane out of a packed bus.
// Lane k occupies bits [W*k+W-1 : W*k].
module fft_lane_select
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W,
    localparam int IW = $clog2(N)
) (
    input  logic [N*W-1:0] bus,
    input  logic [IW-1:0]  index,
    output logic [W-1:0]   lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < N; i++) begin
            if (index == IW'(i)) begin
                lane = bus[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/fft_frame_streamer.sv
// Captures the FFT output buses a fixed latency after frame launch and streams
// the N complex bins one per cycle over valid/ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no frame in flight; waiting for frame_start
// ST_WAIT   | latency counter running down to the FFT output-valid cycle
// ST_STREAM | capture buffer frozen; bins presented in index order
module fft_frame_streamer
    import fft_pkg::*;
#(
    parameter int N       = FFT_N,
    parameter int W       = FFT_W,
    parameter int LATENCY = 40,
    parameter int BITREV  = 0,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(LATENCY) + 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           frame_start,
    input  logic [N*W-1:0] xout_bus,
    input  logic [N*W-1:0] yout_bus,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_re,
    output logic [W-1:0]   out_im,
    output logic [IW-1:0]  out_index,
    output logic           out_last,
    output logic           busy,
    output logic           overrun
);

    fft_state_t     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic [N*W-1:0] cap_re, cap_im;
    logic           capture;
    logic           overrun_nxt;
    logic           handshake;
    logic           final_hs;
    logic [IW-1:0]  rev_idx;
    logic [IW-1:0]  sel_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            overrun <= 1'b0;
            cap_re  <= '0;
            cap_im  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            overrun <= overrun_nxt;
            if (capture) begin
                cap_re <= xout_bus;
                cap_im <= yout_bus;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        capture     = 1'b0;
        overrun_nxt = 1'b0;
        handshake   = (state == ST_STREAM) && out_ready;
        final_hs    = handshake && (idx == IW'(N-1));

        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CW'(LATENCY-1);
                end
            end
            ST_WAIT: begin
                overrun_nxt = frame_start;
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_STREAM;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_STREAM: begin
                if (handshake) begin
                    idx_nxt = idx + IW'(1);
                end
                // A new frame landing on the final handshake chains straight into WAIT.
                if (final_hs) begin
                    if (frame_start) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CW'(LATENCY-1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    overrun_nxt = frame_start;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    generate
        if (IW == FFT_LOG2N) begin : g_rev_pkg
            assign rev_idx = bitrev(idx);
        end else begin : g_rev_generic
            always_comb begin
                rev_idx = '0;
                for (int i = 0; i < IW; i++) begin
                    rev_idx[i] = idx[IW-1-i];
                end
            end
        end
    endgenerate

    assign sel_idx = (BITREV != 0) ? rev_idx : idx;

    fft_lane_select #(.N(N), .W(W)) u_sel_re (
        .bus   (cap_re),
        .index (sel_idx),
        .lane  (out_re)
    );

    fft_lane_select #(.N(N), .W(W)) u_sel_im (
        .bus   (cap_im),
        .index (sel_idx),
        .lane  (out_im)
    );

    assign out_valid = (state == ST_STREAM);
    assign out_last  = out_valid && (idx == IW'(N-1));
    assign out_index = idx;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Bench for fft_frame_streamer: lane-order and bit-reversed instances driven in
// parallel, checked every cycle against an edge-numbered frame model.
module tb_fft_frame_streamer;

    localparam int N  = 32;
    localparam int W  = 16;
    localparam int L  = 40;
    localparam int IW = 5;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           frame_start = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] xout_bus = '0;
    logic [N*W-1:0] yout_bus = '0;

    logic          v0, last0, busy0, ov0;
    logic [W-1:0]  re0, im0;
    logic [IW-1:0] idx0;
    logic          v1, last1, busy1, ov1;
    logic [W-1:0]  re1, im1;
    logic [IW-1:0] idx1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fft_frame_streamer #(.N(N), .W(W), .LATENCY(L), .BITREV(0)) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .xout_bus(xout_bus), .yout_bus(yout_bus),
        .out_valid(v0), .out_ready(out_ready), .out_re(re0), .out_im(im0),
        .out_index(idx0), .out_last(last0), .busy(busy0), .overrun(ov0)
    );

    fft_frame_streamer #(.N(N), .W(W), .LATENCY(L), .BITREV(1)) dut_br (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .xout_bus(xout_bus), .yout_bus(yout_bus),
        .out_valid(v1), .out_ready(out_ready), .out_re(re1), .out_im(im1),
        .out_index(idx1), .out_last(last1), .busy(busy1), .overrun(ov1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rev_index(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int b = 0; b < IW; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Model: a frame accepted at edge t is captured at edge t+L; afterwards
    // 'sent' counts completed handshakes until all N bins have gone.
    logic [W-1:0] m_re [N];
    logic [W-1:0] m_im [N];
    int  t = 0;
    int  cap_at = -1;
    int  sent = 0;
    bit  streaming = 1'b0;
    bit  m_ov = 1'b0;

    always @(posedge clock or negedge reset_n) begin : model
        bit hs;
        bit done;
        if (!reset_n) begin
            cap_at    = -1;
            sent      = 0;
            streaming = 1'b0;
            m_ov      = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_re[k] = '0;
                m_im[k] = '0;
            end
        end else begin
            hs   = streaming && out_ready;
            done = hs && (sent == N-1);
            m_ov = 1'b0;
            if (frame_start) begin
                if ((!streaming && cap_at < 0) || done) cap_at = t + L;
                else m_ov = 1'b1;
            end
            if (hs) begin
                sent++;
                if (done) streaming = 1'b0;
            end
            if (cap_at == t) begin
                for (int k = 0; k < N; k++) begin
                    m_re[k] = xout_bus[k*W +: W];
                    m_im[k] = yout_bus[k*W +: W];
                end
                streaming = 1'b1;
                sent      = 0;
                cap_at    = -1;
            end
            t++;
        end
    end

    always @(negedge clock) begin : compare
        bit exp_busy;
        bit exp_last;
        exp_busy = streaming || (cap_at >= 0);
        exp_last = streaming && (sent == N-1);
        chk("valid", v0, streaming);
        chk("valid_br", v1, streaming);
        chk("busy", busy0, exp_busy);
        chk("busy_br", busy1, exp_busy);
        chk("overrun", ov0, m_ov);
        chk("overrun_br", ov1, m_ov);
        chk("last", last0, exp_last);
        chk("last_br", last1, exp_last);
        if (streaming) begin
            chk("index", idx0, sent);
            chk("index_br", idx1, sent);
            chk("re", re0, m_re[sent]);
            chk("im", im0, m_im[sent]);
            chk("re_br", re1, m_re[rev_index(sent)]);
            chk("im_br", im1, m_im[rev_index(sent)]);
        end
    end

    task automatic set_ramp();
        for (int k = 0; k < N; k++) begin
            xout_bus[k*W +: W] = W'(k * 3);
            yout_bus[k*W +: W] = W'(-k);
        end
    endtask

    task automatic set_random_buses();
        for (int k = 0; k < N; k++) begin
            xout_bus[k*W +: W] = W'($urandom);
            yout_bus[k*W +: W] = W'($urandom);
        end
    endtask

    // Pulse frame_start at this negedge; the first bin must be visible exactly
    // after edge L counted from the accepting edge.
    task automatic pulse_and_time(input string name);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk({name, "_no_overrun"}, ov0, 1'b0);
        repeat (L-1) @(negedge clock);
        chk({name, "_pre"}, v0, 1'b0);
        @(negedge clock);
        chk(name, v0, 1'b1);
        chk({name, "_idx0"}, idx0, 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_idle_in_time"}, (n < 1000), 1'b1);
    endtask

    initial begin : stimulus
        int n;
        int bad;
        int got;
        int order_err;
        int c;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_valid", v0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_overrun", ov0, 1'b0);
        chk("rst_last", last0, 1'b0);
        chk("rst_re", re0, 0);
        chk("rst_im", im0, 0);
        chk("rst_index", idx0, 0);
        reset_n = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (v0 || busy0 || ov0 || v1 || busy1 || ov1) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Lane order / bit-reversed literals, then back-to-back chaining
        set_ramp();
        out_ready = 1'b1;
        pulse_and_time("first_latency");
        chk("lane_re0", re0, 0);
        @(negedge clock);
        chk("lane_re1", re0, 16'd3);
        chk("lane_im1", im0, 16'hFFFF);
        chk("br_re1", re1, 16'd48);
        @(negedge clock);
        @(negedge clock);
        chk("lane_idx3", idx0, 3);
        chk("br_re3", re1, 16'd72);
        chk("br_im3", im1, 16'hFFE8);
        n = 0;
        while (!(v0 && last0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("reach_last", (n < 100), 1'b1);
        chk("last_index", idx0, N-1);
        pulse_and_time("b2b_latency");
        wait_idle("b2b");

        // Backpressure with buses scrambled after capture
        set_random_buses();
        out_ready = 1'b1;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        got = 0;
        order_err = 0;
        c = 0;
        n = 0;
        while (busy0 && n < 600) begin
            out_ready = (c % 3 == 0);
            c++;
            if (v0) set_random_buses();
            if (v0 && out_ready) begin
                if (idx0 != IW'(got)) order_err++;
                got++;
            end
            @(negedge clock);
            n++;
        end
        chk("bp_in_time", (n < 600), 1'b1);
        chk("bp_bins", got, N);
        chk("bp_order", order_err, 0);

        // Overrun during WAIT
        out_ready = 1'b1;
        set_ramp();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        repeat (5) @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("overrun_pulse", ov0, 1'b1);
        @(negedge clock);
        chk("overrun_single", ov0, 1'b0);
        got = 0;
        n = 0;
        while (busy0 && n < 200) begin
            if (v0) got++;
            @(negedge clock);
            n++;
        end
        chk("overrun_bins", got, N);
        repeat (3) @(negedge clock);
        chk("overrun_no_second", busy0, 1'b0);

        // Asynchronous reset mid-stream
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        n = 0;
        while (!(v0 && idx0 == IW'(10)) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("reach_idx10", (n < 200), 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", v0, 1'b0);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_index", idx0, 0);
        chk("arst_re", re0, 0);
        chk("arst_im", im0, 0);
        chk("arst_valid_br", v1, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clock);
            if (v0 || busy0 || v1) bad++;
        end
        chk("arst_no_residue", bad, 0);

        // Randomized traffic
        repeat (3000) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 49) == 0);
            set_random_buses();
            @(negedge clock);
        end
        frame_start = 1'b0;
        out_ready = 1'b1;
        wait_idle("random_drain");

        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Consumer at the output end of the 32-point CORDIC FFT. It waits a fixed latency after an input frame is launched, then captures the FFT's packed real and imaginary output buses in one cycle. It then streams the 32 complex bins out one per cycle over a valid/ready handshake. This feeds the downstream phase-correlation stages (cross-power spectrum, IFFT), which consume serial bins.

## Interface
- `N`, 32: points per frame; power of two.
- `W`, 16: bits per real or imaginary sample, two's complement.
- `LATENCY`, 40: clock cycles from `frame_start` to valid FFT output buses; must be ≥ 1.
- `BITREV`, 0: 0 streams bins in lane order; 1 streams lane `bitrev(k)` at output index `k`.

- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse; the FFT inputs for a new frame were applied this cycle.
- `xout_bus`, in, N*W: packed real outputs of the FFT; lane k (0..N-1) occupies bits [W*k+W-1 : W*k]; lane 0 is bin 0.
- `yout_bus`, in, N*W: packed imaginary outputs of the FFT; same packing as `xout_bus`.
- `out_valid`, out, 1: `out_re`, `out_im`, `out_index` and `out_last` are valid.
- `out_ready`, in, 1: downstream accepts the current bin.
- `out_re`, out, W: real part of the current bin.
- `out_im`, out, W: imaginary part of the current bin.
- `out_index`, out, log2(N): index of the current bin in the output stream.
- `out_last`, out, 1: asserted with `out_index` = N-1.
- `busy`, out, 1: high in WAIT and STREAM.
- `overrun`, out, 1: one-cycle pulse when `frame_start` arrives while a frame is already being handled and is dropped.

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE → WAIT on `frame_start`; the latency counter loads `LATENCY-1`.
- WAIT: the counter decrements each cycle. At count 0 the block registers both buses into a 2·N·W capture buffer, moves to STREAM, and sets `out_index` = 0.
- STREAM: `out_valid` = 1 and the outputs show buffer lane `out_index`, or `bitrev(out_index)` when `BITREV` = 1.
  - A handshake is `out_valid && out_ready`.
  - On a handshake `out_index` increments.
  - A handshake with `out_last` set returns the block to IDLE.
- Stall: while `out_ready` = 0, every output holds stable. Valid must not drop before its handshake.
- `frame_start` in WAIT or STREAM is dropped and `overrun` pulses for one cycle. The active frame is not disturbed.
- Exception: `frame_start` in the same cycle as the final handshake is accepted and the block goes straight to WAIT. No `overrun` pulses and no idle cycle is inserted.
- The buffer is frozen in STREAM. Bus changes after capture have no effect.
- Data passes through unmodified: no scaling, no sign change.

## Timing
- Reset values (asynchronous): state = IDLE; `out_valid`, `out_last`, `busy` and `overrun` = 0; `out_re`, `out_im` and `out_index` = 0; counter = 0; buffer = 0.
- `frame_start` sampled high at edge 0 gives:
  - buses captured at edge `LATENCY`;
  - `out_valid` high after that edge.
- With `out_ready` held high:
  - the N bins occupy N consecutive cycles;
  - the final handshake at edge `LATENCY`+N returns the block to IDLE.
- `busy` is high from the edge after `frame_start` through the final handshake.
- `overrun` is registered: it is high in the cycle after the offending `frame_start`.
- If `reset_n` asserts mid-WAIT or mid-STREAM, the partial frame is discarded. Outputs go to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `fft_pkg` holds:
  - constants `FFT_N` = 32, `FFT_W` = 16, `FFT_LOG2N` = 5;
  - a state enum type;
  - function `bitrev` over `FFT_LOG2N` bits.
- The package is reused by the future IFFT and spectrum blocks.
- One natural sub-module, `fft_lane_select`: a purely combinational N:1 mux of W-bit lanes from a packed bus by index, instantiated for real and for imaginary.
- The counter, FSM and capture buffer live in the top module.

## Test plan
- Reset then idle: hold `frame_start` = 0 for 100 cycles → `out_valid`, `busy` and `overrun` stay 0.
- Lane order (`BITREV` = 0, `out_ready` = 1):
  - stimulus: pulse `frame_start`; lane k of `xout_bus` = k·3 and lane k of `yout_bus` = −k from `LATENCY`−1 onward;
  - required: `out_valid` rises after edge `LATENCY`; 32 consecutive bins with `out_re` = 3k and `out_im` = −k (0xFFFF at k = 1); `out_last` only at index 31; then IDLE.
- Bit-reversed order (`BITREV` = 1), same stimulus → index 1 carries lane 16 (`out_re` = 48), index 3 carries lane 24 (`out_re` = 72).
- Backpressure:
  - stimulus: `out_ready` toggles 1,0,0,1,… and the buses change after capture;
  - required: values hold while stalled; all 32 bins arrive exactly once, in order; the captured values are unaffected by the later bus changes.
- Overrun and back-to-back:
  - a second `frame_start` during WAIT → `overrun` pulses once and only the first frame streams;
  - `frame_start` coincident with the final handshake → no `overrun`; the new frame's first bin appears `LATENCY` edges later.
- Async reset: assert `reset_n` = 0 at index 10 of STREAM → outputs clear without a clock edge; after release, no residual bins appear.
